rv32_fetch_pc: RTL and testbench
================================

Name: rv32_fetch_pc

Overview:
- Owns the architectural PC and fetches instructions from instruction memory over a req/gnt/rvalid handshake.
- Presents one instruction at a time, with its PC, to decode/execute.
- Consumes the redirect produced by the next-PC stage (has-new-pc flag plus target) and flushes any wrong-path fetch.
- At most one memory request is outstanding, and there is a one-entry output slot.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on rv32_instr when no valid instruction is held.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- rv32_has_new_pc  in  1  redirect request from the next-PC stage, sampled every cycle.
- rv32_next_pc_val  in  XLEN  redirect target.
- rv32_dec_ready  in  1  downstream accepts the instruction this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; arrives ≥1 cycle after gnt.
- imem_rdata  in  32  fetched instruction.
- rv32_instr_valid  out  1  output slot holds an instruction.
- rv32_instr  out  32  instruction.
- rv32_instr_pc  out  XLEN  PC of rv32_instr; feeds the current-PC input of the next-PC stage.
- rv32_fetch_misalign  out  1  one-cycle pulse when a redirect target has addr[1:0]!=0.

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets:
  - pc=RESET_PC, state=IDLE, drop=0;
  - imem_req=0, imem_addr=RESET_PC;
  - rv32_instr_valid=0, rv32_instr=NOP_INSTR, rv32_instr_pc=RESET_PC;
  - rv32_fetch_misalign=0.
- States: IDLE, REQ, WAIT.
- IDLE: one cycle after reset release, then goes to REQ. A redirect in IDLE updates pc.
- REQ:
  - imem_req=1 and imem_addr=pc, but only when the slot is free: rv32_instr_valid=0, or (rv32_instr_valid & rv32_dec_ready) this cycle. Otherwise imem_req=0 and the state stays REQ.
  - On req&gnt: inflight_pc<=pc, pc<=pc+4 (wraps modulo 2^XLEN), go to WAIT.
- WAIT:
  - imem_req=0.
  - On rvalid with drop=0: rv32_instr<=imem_rdata, rv32_instr_pc<=inflight_pc, rv32_instr_valid<=1, go to REQ.
  - On rvalid with drop=1: discard the data, drop<=0, go to REQ.
- Output slot:
  - Holds its contents stable while valid & !dec_ready.
  - valid & dec_ready with no new fill: valid<=0 and rv32_instr<=NOP_INSTR.
  - The slot is always empty when a response arrives, so no skid buffer is needed.
- Redirect (rv32_has_new_pc=1) takes priority over every other pc update in that cycle:
  - pc<=rv32_next_pc_val with bits[1:0] forced to 0.
  - rv32_fetch_misalign<=|rv32_next_pc_val[1:0].
  - rv32_instr_valid<=0, even if dec_ready is also high; the handshake completes and then the slot is flushed.
  - In REQ with gnt in the same cycle: the old address was granted, so go to WAIT with drop<=1.
  - In REQ without gnt: next cycle imem_addr = new pc. The memory tolerates an address change while req is high and ungranted.
  - In WAIT without rvalid: drop<=1.
  - In WAIT with rvalid in the same cycle: the data is discarded, drop stays 0, go to REQ.
  - Redirect while drop=1 already: drop stays 1; there is still only one outstanding request.
- Throughput: with a 1-cycle rvalid latency and dec_ready held high, one instruction every 2 cycles.
  - Latency from gnt to instr_valid = rvalid latency + 1 register stage.
- Reset asserted mid-transaction returns all state to reset values immediately. A late rvalid arriving after reset release and before the first gnt is ignored, because the state is IDLE/REQ.

Test Plan:
- Reset release, 1-cycle-latency memory, dec_ready=1 → imem_addr sequence 0x0,0x4,0x8; rv32_instr_pc tracks it; instr_valid high every other cycle.
- dec_ready=0 for 5 cycles with a valid instruction held → rv32_instr and rv32_instr_pc stable; imem_req=0 throughout; fetch resumes the cycle dec_ready=1.
- Redirect to 0x100 in WAIT before rvalid → rdata for old address 0x8 is dropped; next imem_addr=0x100; first valid output has instr_pc=0x100.
- Redirect to 0x200 in the same cycle as req&gnt at 0x4 → response for 0x4 dropped; next request at 0x200; no wrong-path instr_valid.
- Redirect target 0x102 → fetch address 0x100; rv32_fetch_misalign pulses exactly one cycle.
- rst_n asserted during WAIT, then released → outputs at reset values; first request at RESET_PC; stale rvalid ignored.

Source files
------------

// File: rtl/rv32_fetch_pc.sv
// RV32 fetch stage: owns the architectural PC, fetches over req/gnt/rvalid.
// One outstanding request, one-entry output slot, redirect with flush.
module rv32_fetch_pc #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rv32_has_new_pc,
    input  logic [XLEN-1:0] rv32_next_pc_val,
    input  logic            rv32_dec_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            rv32_instr_valid,
    output logic [31:0]     rv32_instr,
    output logic [XLEN-1:0] rv32_instr_pc,
    output logic            rv32_fetch_misalign
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            drop_q;
    logic            valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            misalign_q;

    logic            redirect;
    logic [XLEN-1:0] redir_pc;
    logic            slot_free;
    logic            fire;
    logic            resp;
    logic            fill;

    assign redirect  = rv32_has_new_pc;
    assign redir_pc  = {rv32_next_pc_val[XLEN-1:2], 2'b00};
    assign slot_free = !valid_q || rv32_dec_ready;
    assign fire      = imem_req && imem_gnt;
    assign resp      = (state_q == ST_WAIT) && imem_rvalid;
    assign fill      = resp && !drop_q && !redirect;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE lasts one cycle, REQ until granted, WAIT until data
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (fire) state_d = ST_WAIT;
            ST_WAIT: if (imem_rvalid) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: request only when the response will find the slot free
    always_comb begin
        imem_req = 1'b0;
        if (state_q == ST_REQ) begin
            imem_req = slot_free;
        end
    end

    assign imem_addr = pc_q;

    // PC: redirect wins over the sequential +4 advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            if (fire) begin
                inflight_pc_q <= pc_q;
            end
            if (redirect) begin
                pc_q <= redir_pc;
            end else if (fire) begin
                pc_q <= pc_q + PC_STEP;
            end
        end
    end

    // Drop flag: marks the single in-flight response as wrong-path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else if (resp) begin
            drop_q <= 1'b0;
        end else if (redirect && (fire || state_q == ST_WAIT)) begin
            drop_q <= 1'b1;
        end
    end

    // Output slot: flush on redirect, fill on good data, empty on handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
        end else if (redirect) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (fill) begin
            valid_q    <= 1'b1;
            instr_q    <= imem_rdata;
            instr_pc_q <= inflight_pc_q;
        end else if (valid_q && rv32_dec_ready) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end
    end

    // Misalign pulse follows each redirect with a non-word target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect && (rv32_next_pc_val[1:0] != 2'b00);
        end
    end

    assign rv32_instr_valid    = valid_q;
    assign rv32_instr          = instr_q;
    assign rv32_instr_pc       = instr_pc_q;
    assign rv32_fetch_misalign = misalign_q;

endmodule

// File: tb/tb_rv32_fetch_pc.sv
// Bench for rv32_fetch_pc: directed scenarios plus random traffic
// checked against a program-order reference model and a memory model.
module tb_rv32_fetch_pc;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        has_new_pc;
    logic [31:0] next_pc_val;
    logic        dec_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign;

    rv32_fetch_pc dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .rv32_has_new_pc     (has_new_pc),
        .rv32_next_pc_val    (next_pc_val),
        .rv32_dec_ready      (dec_ready),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_gnt            (imem_gnt),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .rv32_instr_valid    (instr_valid),
        .rv32_instr          (instr),
        .rv32_instr_pc       (instr_pc),
        .rv32_fetch_misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // model state
    logic [31:0] exp_pc;
    bit          outstanding;
    logic [31:0] resp_addr;
    int          resp_cnt;
    int          lat;
    bit          prev_redir;
    logic [31:0] prev_tgt;
    int          delivered;
    logic [31:0] req_log[$];
    bit          valid_log[$];

    // pre-edge observations of the last cycle
    bit          obs_req;
    logic [31:0] obs_addr;
    bit          obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_instr;
    bit          obs_mis;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3} + 32'h1234_0000;
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc     = RESET_PC;
        prev_redir = 1'b0;
        prev_tgt   = '0;
        req_log.delete();
        valid_log.delete();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        has_new_pc  = 1'b0;
        next_pc_val = '0;
        dec_ready   = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        outstanding = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: drive at posedge+1, check before the edge, update model
    task automatic cycle(input bit rdy, input bit redir,
                         input logic [31:0] tgt, input bit g);
        bit          rv;
        logic [31:0] rd;
        bit          exp_mis;
        rv = 1'b0;
        rd = '0;
        if (outstanding) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                rv = 1'b1;
                rd = mem_word(resp_addr);
            end
        end
        dec_ready   = rdy;
        has_new_pc  = redir;
        next_pc_val = tgt;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_pc    = instr_pc;
        obs_instr = instr;
        obs_mis   = misalign;
        expect_eq("one_outstanding", imem_req && outstanding, 0);
        if (imem_req) begin
            expect_eq("addr_align", imem_addr[1:0], 0);
            expect_eq("req_slot_free", !instr_valid || rdy, 1);
        end
        if (instr_valid) begin
            expect_eq("instr_pc_order", instr_pc, exp_pc);
            expect_eq("instr_data", instr, mem_word(exp_pc));
        end else begin
            expect_eq("instr_nop", instr, NOP);
        end
        exp_mis = prev_redir && (prev_tgt[1:0] != 2'b00);
        expect_eq("misalign", misalign, exp_mis);
        if (prev_redir) expect_eq("flush", instr_valid, 0);
        @(posedge clk);
        if (rv) outstanding = 1'b0;
        if (obs_req && g && !outstanding) begin
            outstanding = 1'b1;
            resp_addr   = obs_addr;
            resp_cnt    = lat;
            req_log.push_back(obs_addr);
        end
        if (obs_valid && rdy) begin
            delivered++;
            exp_pc = exp_pc + 32'd4;
        end
        if (redir) exp_pc = {tgt[31:2], 2'b00};
        prev_redir = redir;
        prev_tgt   = tgt;
        valid_log.push_back(obs_valid);
        #1;
    endtask

    task automatic run_until_valid(input string tag, input logic [31:0] pc0,
                                   input int n0, output int mis);
        bit got;
        got = 1'b0;
        mis = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle(1, 0, '0, 1);
            mis += int'(obs_mis);
            if (obs_valid) begin
                got = 1'b1;
                expect_eq({tag, "_first_pc"}, obs_pc, pc0);
            end
        end
        expect_eq({tag, "_seen_valid"}, got, 1);
        expect_eq({tag, "_has_req"}, req_log.size() > n0, 1);
        if (req_log.size() > n0) begin
            expect_eq({tag, "_first_addr"}, req_log[n0], pc0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int mis;
        logic [31:0] tgt;
        n_chk     = 0;
        n_fail    = 0;
        delivered = 0;
        lat       = 1;

        // reset values
        do_reset();
        expect_eq("rst_req", imem_req, 0);
        expect_eq("rst_addr", imem_addr, RESET_PC);
        expect_eq("rst_valid", instr_valid, 0);
        expect_eq("rst_instr", instr, NOP);
        expect_eq("rst_pc", instr_pc, RESET_PC);
        expect_eq("rst_mis", misalign, 0);

        // streaming with 1-cycle memory
        for (int i = 0; i < 9; i++) cycle(1, 0, '0, 1);
        expect_eq("t1_nreq", req_log.size(), 4);
        expect_eq("t1_addr0", req_log[0], 32'h0);
        expect_eq("t1_addr1", req_log[1], 32'h4);
        expect_eq("t1_addr2", req_log[2], 32'h8);
        for (int i = 2; i < 9; i++) begin
            expect_eq($sformatf("t1_valid%0d", i), valid_log[i],
                      (i >= 3 && i % 2 == 1) ? 1 : 0);
        end

        // backpressure holds the slot and stalls fetch
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, '0, 1);
            expect_eq("t2_valid", obs_valid, 1);
            expect_eq("t2_pc", obs_pc, 32'h0);
            expect_eq("t2_instr", obs_instr, mem_word(32'h0));
            expect_eq("t2_req", obs_req, 0);
        end
        cycle(1, 0, '0, 1);
        expect_eq("t2_resume_req", obs_req, 1);
        expect_eq("t2_resume_addr", obs_addr, 32'h4);

        // redirect while waiting for data
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, '0, 1);
        lat = 3;
        cycle(1, 0, '0, 1);
        expect_eq("t3_req8", obs_req ? obs_addr : 32'hFFFF_FFFF, 32'h8);
        cycle(1, 1, 32'h100, 1);
        lat = 1;
        n0 = req_log.size();
        run_until_valid("t3", 32'h100, n0, mis);
        expect_eq("t3_mis", mis, 0);

        // redirect in the same cycle as the grant
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 1);
        cycle(1, 1, 32'h200, 1);
        expect_eq("t4_req4", obs_req ? obs_addr : 32'hFFFF_FFFF, 32'h4);
        n0 = req_log.size();
        run_until_valid("t4", 32'h200, n0, mis);
        expect_eq("t4_mis", mis, 0);

        // misaligned redirect target
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 1);
        cycle(1, 1, 32'h102, 1);
        n0 = req_log.size();
        run_until_valid("t5", 32'h100, n0, mis);
        expect_eq("t5_mis_pulses", mis, 1);

        // reset during WAIT with a late response
        do_reset();
        lat = 3;
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, 1);
        rst_n = 1'b0;
        #1;
        expect_eq("t6_req", imem_req, 0);
        expect_eq("t6_addr", imem_addr, RESET_PC);
        expect_eq("t6_valid", instr_valid, 0);
        expect_eq("t6_instr", instr, NOP);
        expect_eq("t6_pc", instr_pc, RESET_PC);
        outstanding = 1'b1;
        resp_addr   = 32'hDEAD_BEE0;
        resp_cnt    = 1;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        lat = 1;
        cycle(1, 0, '0, 0);
        cycle(1, 0, '0, 0);
        expect_eq("t6_first_req", obs_req ? obs_addr : 32'hFFFF_FFFF,
                  RESET_PC);
        run_until_valid("t6", RESET_PC, 0, mis);

        // random traffic against the reference model
        do_reset();
        delivered = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0)
                tgt = 32'hFFFF_FFFC + $urandom_range(0, 3);
            else
                tgt = $urandom_range(0, 1023);
            lat = $urandom_range(1, 3);
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  tgt, $urandom_range(0, 9) < 6);
        end
        expect_eq("rand_progress", delivered > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
